// File: rtl/add16_arbiter.sv
// add16_arbiter: two requesters share a single 16-bit ripple-carry adder.
// A round-robin arbiter picks one requester per cycle. The sum of the granted
// requester lands in a one-deep response register, so there is one cycle of
// latency. Results can be issued back to back, one per cycle.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset
//   req0_valid/ready/a/b    requester 0 handshake and operands
//   req1_valid/ready/a/b    requester 1 handshake and operands
//   rsp_valid/ready         response handshake
//   rsp_sum                 registered 16-bit sum (modulo 2^16)
//   rsp_id                  requester that produced rsp_sum
module add16_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_sum,
  output logic        rsp_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_prio;
  logic [15:0] r_rsp_sum;
  logic        r_rsp_id;

  logic        w_can_accept;
  logic        w_gnt_any;
  logic        w_gnt_id;
  logic        w_req_xfer;
  logic [15:0] w_op_a;
  logic [15:0] w_op_b;
  logic [15:0] w_carry;
  logic [15:0] w_sum;

  // Grant: a single valid requester always wins. When both are valid, prio
  // decides the winner.
  always_comb begin
    w_gnt_any = req0_valid | req1_valid;
    w_gnt_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      w_gnt_id = r_prio;
    end else if (req1_valid) begin
      w_gnt_id = 1'b1;
    end
  end

  // The response register can take new data when it is empty or being drained
  assign w_can_accept = (r_state == EMPTY) || rsp_ready;
  assign w_req_xfer   = w_can_accept && w_gnt_any;

  assign w_op_a = w_gnt_id ? req1_a : req0_a;
  assign w_op_b = w_gnt_id ? req1_b : req0_b;

  // Ripple-carry adder with carry-in 0. The carry out of bit 15 is never
  // formed, because the sum wraps modulo 2^16.
  always_comb begin
    w_carry = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      w_carry[i+1] = (w_op_a[i] & w_op_b[i]) | (w_carry[i] & (w_op_a[i] ^ w_op_b[i]));
    end
    w_sum = w_op_a ^ w_op_b ^ w_carry;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_req_xfer) w_state_nxt = FULL;
      FULL:  if (rsp_ready && !w_req_xfer) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    rsp_valid  = (r_state == FULL);
    req0_ready = w_req_xfer && !w_gnt_id;
    req1_ready = w_req_xfer &&  w_gnt_id;
  end

  // Datapath and round-robin pointer. They change only when a request
  // transfer happens, so a held result stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_sum <= '0;
      r_rsp_id  <= 1'b0;
      r_prio    <= 1'b0;
    end else if (w_req_xfer) begin
      r_rsp_sum <= w_sum;
      r_rsp_id  <= w_gnt_id;
      r_prio    <= ~w_gnt_id;
    end
  end

  assign rsp_sum = r_rsp_sum;
  assign rsp_id  = r_rsp_id;

endmodule

// File: tb/tb_add16_arbiter.sv
// Testbench for add16_arbiter. The bench runs directed scenarios and then
// randomized traffic. Every cycle is checked against a transaction-level
// reference model.
module tb_add16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_sum;
  logic        rsp_id;

  add16_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state: the held response and the round-robin pointer
  logic        m_valid;
  logic [15:0] m_sum;
  logic        m_id;
  logic        m_prio;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_sum   = 16'h0000;
    m_id    = 1'b0;
    m_prio  = 1'b0;
  endtask

  task automatic set_req(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                         input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
  endtask

  // One clock cycle. The task checks the ready outputs before the edge and the
  // response outputs after it, against the model. Inputs must already be driven.
  task automatic cycle();
    logic       who;
    logic       any;
    logic       can;
    logic       take;
    logic [16:0] full_sum;
    #1;
    any = req0_valid || req1_valid;
    if (req0_valid && req1_valid) who = m_prio;
    else who = req1_valid;
    can  = !m_valid || rsp_ready;
    take = can && any;
    chk("req0_ready", req0_ready, take && (who == 1'b0));
    chk("req1_ready", req1_ready, take && (who == 1'b1));
    @(posedge clk);
    if (take) begin
      full_sum = who ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
      m_valid  = 1'b1;
      m_sum    = full_sum[15:0];
      m_id     = who;
      m_prio   = !who;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("rsp_sum", rsp_sum, m_sum);
      chk("rsp_id", rsp_id, m_id);
    end
  endtask

  logic [15:0] held_sum;
  logic        held_id;

  initial begin
    model_reset();
    rst_n = 1'b0;
    set_req(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    #2;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_sum", rsp_sum, 16'h0000);
    chk("rst_id", rsp_id, 1'b0);
    req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 1'b1);
    chk("rst_req1_ready", req1_ready, 1'b0);
    req0_valid = 1'b0;
    #4;
    rst_n = 1'b1;

    // Contention: both valid, draining every cycle, strict alternation from 0
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 16'(i), 16'h0100, 1'b1, 16'(i), 16'h0200, 1'b1);
      cycle();
      chk("contend_id", rsp_id, (i % 2));
      chk("contend_valid", rsp_valid, 1'b1);
    end

    // Single add from requester 0
    set_req(1'b1, 16'h0003, 16'h0004, 1'b0, '0, '0, 1'b1);
    cycle();
    chk("add_sum", rsp_sum, 16'h0007);
    chk("add_id", rsp_id, 1'b0);

    // Wrap-around on requester 1
    set_req(1'b0, '0, '0, 1'b1, 16'hFFFF, 16'h0002, 1'b1);
    cycle();
    chk("wrap_sum", rsp_sum, 16'h0001);
    chk("wrap_id", rsp_id, 1'b1);
    set_req(1'b0, '0, '0, 1'b1, 16'h8000, 16'h8000, 1'b1);
    cycle();
    chk("wrap0_sum", rsp_sum, 16'h0000);

    // Backpressure: the held result must not move while rsp_ready is low
    set_req(1'b1, 16'h1111, 16'h2222, 1'b0, '0, '0, 1'b1);
    cycle();
    held_sum = rsp_sum;
    held_id  = rsp_id;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 16'($urandom), 16'($urandom), 1'b1, 16'($urandom), 16'($urandom), 1'b0);
      cycle();
      chk("bp_sum_stable", rsp_sum, held_sum);
      chk("bp_id_stable", rsp_id, held_id);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_drain_id", rsp_id, !held_id);

    // Asynchronous reset while holding 0x1234
    set_req(1'b1, 16'h1000, 16'h0234, 1'b0, '0, '0, 1'b1);
    cycle();
    chk("pre_rst_sum", rsp_sum, 16'h1234);
    set_req(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 1'b0);
    chk("async_rst_sum", rsp_sum, 16'h0000);
    model_reset();
    rst_n = 1'b1;
    set_req(1'b1, 16'h0001, 16'h0001, 1'b1, 16'h0002, 16'h0002, 1'b1);
    cycle();
    chk("post_rst_id", rsp_id, 1'b0);

    // Randomized traffic, including occasional asynchronous reset pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_rst_valid", rsp_valid, 1'b0);
        chk("rand_rst_sum", rsp_sum, 16'h0000);
        model_reset();
        rst_n = 1'b1;
      end
      set_req(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 2) != 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add16_arbiter.md
ADD16_ARBITER -- requirements
Module: add16_arbiter

Interface
REQ-001 The block SHALL have no parameters; all data widths are fixed at 16 bits, with index 0 the least significant bit on every data bus.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operand pair to add.
REQ-005 req0_ready  output  1  the block accepts requester 0's operands this cycle.
REQ-006 req0_a, req0_b  input  16 each  requester 0 operands.
REQ-007 req1_valid  input  1  requester 1 has an operand pair to add.
REQ-008 req1_ready  output  1  the block accepts requester 1's operands this cycle.
REQ-009 req1_a, req1_b  input  16 each  requester 1 operands.
REQ-010 rsp_valid  output  1  a registered result is held.
REQ-011 rsp_ready  input  1  the consumer takes the result this cycle.
REQ-012 rsp_sum  output  16  registered sum.
REQ-013 rsp_id  output  1  requester that produced rsp_sum (0 or 1).

Function
REQ-014 One shared combinational 16-bit ripple adder SHALL compute a + b of the granted requester.
- carry-in is 0.
- The result is modulo 2^16; carry-out is discarded.
REQ-015 A transfer on requester k SHALL occur when reqk_valid and reqk_ready are both 1 at a rising edge.
REQ-016 A response transfer SHALL occur when rsp_valid and rsp_ready are both 1 at a rising edge.
REQ-017 can_accept SHALL equal (!rsp_valid || rsp_ready).
- Combinational path from rsp_ready to reqk_ready is permitted.
REQ-018 Grant selection SHALL be combinational from req0_valid, req1_valid and a 1-bit priority pointer prio.
- Only one valid: grant that requester.
- Both valid: grant requester prio.
- Neither valid: no grant.
REQ-019 reqk_ready SHALL be 1 only when can_accept is 1 and requester k is granted; req0_ready and req1_ready SHALL never both be 1.
REQ-020 State machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); state and rsp_valid are the same flop.
REQ-021 EMPTY -> FULL on a request transfer.
REQ-022 FULL -> FULL when a response transfer and a request transfer occur in the same edge.
- rsp_sum/rsp_id are overwritten with the new result.
- Back-to-back throughput is one result per cycle.
REQ-023 FULL -> EMPTY on a response transfer with no request transfer.
REQ-024 FULL holds with rsp_sum/rsp_id stable while rsp_ready=0, regardless of request inputs.
REQ-025 Latency SHALL be 1 cycle: operands accepted at edge N appear on rsp_sum with rsp_valid=1 immediately after edge N.
REQ-026 On a request transfer from requester k, prio SHALL become !k (round-robin); otherwise prio holds.
- No requester is starved while the consumer keeps draining.
REQ-027 Operand inputs SHALL be sampled only at the transfer edge; later changes SHALL NOT affect a held result.
REQ-028 A requester dropping valid without a transfer SHALL be ignored and SHALL NOT change prio.

Reset
REQ-029 While rst_n=0, regardless of clk, the block SHALL hold these values:
- rsp_valid=0, rsp_sum=16'h0000, rsp_id=0, prio=0.
- req0_ready and req1_ready follow REQ-019 from those reset values.
REQ-030 Reset asserted mid-operation SHALL discard any held result immediately.
- No response transfer is reported for it.
REQ-031 The first rising edge after rst_n deasserts SHALL behave as a normal edge from the EMPTY state.

Verification
REQ-032 Single add: req0 a=16'h0003, b=16'h0004, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_sum=16'h0007, rsp_id=0.
REQ-033 Wrap-around: req1 a=16'hFFFF, b=16'h0002 -> rsp_sum=16'h0001, rsp_id=1.
- Repeat with a=16'h8000, b=16'h8000 -> rsp_sum=16'h0000.
REQ-034 Contention: both valid every cycle, rsp_ready=1, 6 cycles -> rsp_id sequence 0,1,0,1,0,1 and one result per cycle.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles after a result, both requesters valid -> req0_ready=req1_ready=0, and rsp_sum/rsp_id are stable throughout.
- Raise rsp_ready -> the held result drains and the other requester is accepted in that same edge.
REQ-036 Reset mid-operation: rst_n low while FULL with rsp_sum=16'h1234 -> rsp_valid=0 and rsp_sum=16'h0000 without a clock edge.
- After release, with both valid, requester 0 is granted first.
